// File: rtl/m_result_uart.sv
// ---------------------------------------------------------------------------
// m_result_uart
//
// Reports a 32-bit processor result word as text over a UART TX line.
// A trigger (a manual send pulse or the rising edge of the halt level)
// snapshots the result word. The block then sends 8 uppercase hex digits,
// most significant nibble first, followed by CR LF. Each character uses 8N1
// framing, and characters follow each other with no idle gap.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per UART bit (>= 2)
//
// Ports:
//   w_clk    in   system clock, rising edge
//   w_rst_n  in   asynchronous active-low reset
//   w_din    in   [31:0] result word
//   w_halt   in   halt level; its rising edge triggers one frame
//   w_send   in   single-cycle manual trigger
//   r_txd    out  serial data, idle high, driven from a flop
//   r_busy   out  high while a frame is in flight
//   r_done   out  one-cycle pulse on the cycle r_busy falls
// ---------------------------------------------------------------------------
module m_result_uart #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        w_clk,
  input  logic        w_rst_n,
  input  logic [31:0] w_din,
  input  logic        w_halt,
  input  logic        w_send,
  output logic        r_txd,
  output logic        r_busy,
  output logic        r_done
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] TIMER_MAX = TW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    LAST_CHAR = 4'd9;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_q, bit_d;
  logic [3:0]    char_q, char_d;
  logic [31:0]   snap_q, snap_d;
  logic          halt_q, halt_d;
  logic          txd_q, txd_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic trig;
  logic wrap;
  logic [7:0] next_byte;

  // Characters 0..7 are hex digits of the snapshot, MSB nibble first;
  // characters 8 and 9 are CR and LF.
  function automatic logic [7:0] char_byte(input logic [3:0] idx,
                                           input logic [31:0] word);
    logic [31:0] shifted;
    logic [7:0]  nib;
    shifted = word << {idx[2:0], 2'b00};
    nib     = {4'h0, shifted[31:28]};
    if (idx <= 4'd7) begin
      char_byte = (nib < 8'd10) ? (8'h30 + nib) : (8'h37 + nib);
    end else if (idx == 4'd8) begin
      char_byte = 8'h0D;
    end else begin
      char_byte = 8'h0A;
    end
  endfunction

  assign trig = w_send | (w_halt & ~halt_q);
  assign wrap = (timer_q == TIMER_MAX);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    bit_d   = bit_q;
    char_d  = char_q;
    snap_d  = snap_q;
    halt_d  = w_halt;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (trig) begin
          snap_d  = w_din;
          char_d  = 4'd0;
          bit_d   = 3'd0;
          timer_d = '0;
          state_d = START;
        end
      end
      START: begin
        if (wrap) begin
          timer_d = '0;
          bit_d   = 3'd0;
          state_d = DATA;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      DATA: begin
        if (wrap) begin
          timer_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      STOP: begin
        if (wrap) begin
          timer_d = '0;
          if (char_q == LAST_CHAR) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            char_d  = char_q + 4'd1;
            state_d = START;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase

    // The line level is decoded from the next state, so the registered
    // output changes on the same edge as the state and stays glitch-free.
    next_byte = char_byte(char_d, snap_d);
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = next_byte[bit_d];
      default: txd_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      bit_q   <= 3'd0;
      char_q  <= 4'd0;
      snap_q  <= 32'd0;
      halt_q  <= 1'b0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      char_q  <= char_d;
      snap_q  <= snap_d;
      halt_q  <= halt_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign r_txd  = txd_q;
  assign r_busy = busy_q;
  assign r_done = done_q;

endmodule
